// File: rtl/mem_pkg.sv
// Shared store-path definitions: control encodings, FSM states and size-to-strobe masks.
// Pure declarations, no logic.
package mem_pkg;

  localparam logic [2:0] CTRL_SB = 3'b001;
  localparam logic [2:0] CTRL_SH = 3'b010;
  localparam logic [2:0] CTRL_SW = 3'b011;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR0  = 2'd1,
    ST_WR1  = 2'd2
  } state_t;

  // An all-zero mask doubles as the "illegal control" indication.
  function automatic logic [3:0] ctrl_mask(input logic [2:0] ctrl);
    case (ctrl)
      CTRL_SB: ctrl_mask = MASK_B;
      CTRL_SH: ctrl_mask = MASK_H;
      CTRL_SW: ctrl_mask = MASK_W;
      default: ctrl_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_shifter.sv
// Combinational: places right-justified store data onto a 64-bit two-word lane image and
// builds the matching 8-bit strobe; no state, no backpressure.
module store_lane_shifter
  import mem_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_control,
  output logic [63:0] o_lane,
  output logic [7:0]  o_strb
);

  logic [3:0]  w_mask;
  logic [31:0] w_data_m;

  assign w_mask   = ctrl_mask(i_control);
  assign w_data_m = i_data & {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};
  assign o_lane   = {32'b0, w_data_m} << {i_off, 3'b000};
  assign o_strb   = {4'b0, w_mask} << i_off;

endmodule

// File: rtl/mem_store_unit.sv
// Store writer: one request -> one or two word-aligned bus beats, first beat the cycle after accept.
// Beats hold until mem_ready; requests are only accepted in IDLE; done/err pulse one cycle.
module mem_store_unit
  import mem_pkg::*;
#(
  parameter logic SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [2:0]  req_control,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        done,
  output logic        err
);

  state_t      r_state, w_state_nxt;
  logic        r_mem_valid, w_mem_valid_nxt;
  logic [31:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [3:0]  r_mem_wstrb, w_mem_wstrb_nxt;
  logic [31:0] r_b1_addr, w_b1_addr_nxt;
  logic [31:0] r_b1_wdata, w_b1_wdata_nxt;
  logic [3:0]  r_b1_wstrb, w_b1_wstrb_nxt;
  logic        r_split, w_split_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;

  logic [63:0] w_lane;
  logic [7:0]  w_strb;
  logic [31:0] w_b0_addr;
  logic        w_legal;
  logic        w_need_split;

  store_lane_shifter u_shifter (
    .i_data   (req_data),
    .i_off    (req_addr[1:0]),
    .i_control(req_control),
    .o_lane   (w_lane),
    .o_strb   (w_strb)
  );

  assign w_b0_addr    = {req_addr[31:2], 2'b00};
  assign w_legal      = (ctrl_mask(req_control) != 4'b0000);
  assign w_need_split = |w_strb[7:4];

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_valid_nxt = r_mem_valid;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_wstrb_nxt = r_mem_wstrb;
    w_b1_addr_nxt   = r_b1_addr;
    w_b1_wdata_nxt  = r_b1_wdata;
    w_b1_wstrb_nxt  = r_b1_wstrb;
    w_split_nxt     = r_split;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!w_legal || (w_need_split && !SPLIT_EN)) begin
            w_done_nxt = 1'b1;
            w_err_nxt  = 1'b1;
          end else begin
            w_mem_valid_nxt = 1'b1;
            w_mem_addr_nxt  = w_b0_addr;
            w_mem_wdata_nxt = w_lane[31:0];
            w_mem_wstrb_nxt = w_strb[3:0];
            // Second beat is precomputed so it can follow the first handshake with no bubble.
            w_b1_addr_nxt   = w_b0_addr + 32'd4;
            w_b1_wdata_nxt  = w_lane[63:32];
            w_b1_wstrb_nxt  = w_strb[7:4];
            w_split_nxt     = w_need_split;
            w_state_nxt     = ST_WR0;
          end
        end
      end
      ST_WR0: begin
        if (mem_ready) begin
          if (r_split) begin
            w_mem_addr_nxt  = r_b1_addr;
            w_mem_wdata_nxt = r_b1_wdata;
            w_mem_wstrb_nxt = r_b1_wstrb;
            w_state_nxt     = ST_WR1;
          end else begin
            w_mem_valid_nxt = 1'b0;
            w_mem_addr_nxt  = 32'd0;
            w_mem_wdata_nxt = 32'd0;
            w_mem_wstrb_nxt = 4'd0;
            w_done_nxt      = 1'b1;
            w_state_nxt     = ST_IDLE;
          end
        end
      end
      ST_WR1: begin
        if (mem_ready) begin
          w_mem_valid_nxt = 1'b0;
          w_mem_addr_nxt  = 32'd0;
          w_mem_wdata_nxt = 32'd0;
          w_mem_wstrb_nxt = 4'd0;
          w_done_nxt      = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_b1_addr   <= 32'd0;
      r_b1_wdata  <= 32'd0;
      r_b1_wstrb  <= 4'd0;
      r_split     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_wstrb <= w_mem_wstrb_nxt;
      r_b1_addr   <= w_b1_addr_nxt;
      r_b1_wdata  <= w_b1_wdata_nxt;
      r_b1_wstrb  <= w_b1_wstrb_nxt;
      r_split     <= w_split_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_store_unit.sv
// Bench for mem_store_unit: a split-enabled and a split-disabled instance driven with directed
// and random stores, checked beat by beat against a byte-level reference model.
module tb_mem_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic [31:0] req_addr    [2];
  logic [31:0] req_data    [2];
  logic [2:0]  req_control [2];
  logic        mem_valid   [2];
  logic        mem_ready   [2];
  logic [31:0] mem_addr    [2];
  logic [31:0] mem_wdata   [2];
  logic [3:0]  mem_wstrb   [2];
  logic        done        [2];
  logic        err         [2];

  int n_checks = 0;
  int n_fail   = 0;

  int          exp_nb;
  logic [31:0] exp_addr [2];
  logic [31:0] exp_data [2];
  logic [3:0]  exp_strb [2];
  logic        exp_err;

  always #5 clk = ~clk;

  mem_store_unit #(.SPLIT_EN(1'b1)) u_dut_split (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_data(req_data[0]), .req_control(req_control[0]),
    .mem_valid(mem_valid[0]), .mem_ready(mem_ready[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]), .done(done[0]), .err(err[0])
  );

  mem_store_unit #(.SPLIT_EN(1'b0)) u_dut_nosplit (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_data(req_data[1]), .req_control(req_control[1]),
    .mem_valid(mem_valid[1]), .mem_ready(mem_ready[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]), .done(done[1]), .err(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Walk the stored bytes one address at a time and bucket them by word.
  task automatic model(input int u, input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] ctrl);
    int          n;
    int          lane;
    logic [31:0] a;
    logic [31:0] w;
    exp_nb  = 0;
    exp_err = 1'b0;
    for (int b = 0; b < 2; b++) begin
      exp_addr[b] = 32'd0;
      exp_data[b] = 32'd0;
      exp_strb[b] = 4'd0;
    end
    case (ctrl)
      3'b001:  n = 1;
      3'b010:  n = 2;
      3'b011:  n = 4;
      default: n = 0;
    endcase
    if (n == 0) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      a    = addr + i;
      w    = a & 32'hFFFF_FFFC;
      lane = int'(a[1:0]);
      if (exp_nb == 0 || w != exp_addr[exp_nb-1]) begin
        exp_addr[exp_nb] = w;
        exp_nb++;
      end
      exp_data[exp_nb-1][8*lane +: 8] = data[8*i +: 8];
      exp_strb[exp_nb-1][lane]        = 1'b1;
    end
    if (exp_nb == 2 && u == 1) begin
      exp_nb  = 0;
      exp_err = 1'b1;
    end
  endtask

  // Entered and left at a negedge; the next store may be accepted in the done cycle.
  // stall < 0: random mem_ready per cycle; otherwise ready low for 'stall' cycles per beat.
  task automatic run_store(input int u, input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] ctrl, input int stall);
    int   k;
    logic rdy;
    model(u, addr, data, ctrl);
    chk("req_ready_idle", req_ready[u], 1);
    req_valid[u]   = 1'b1;
    req_addr[u]    = addr;
    req_data[u]    = data;
    req_control[u] = ctrl;
    mem_ready[u]   = 1'($urandom % 2);
    @(negedge clk);
    if (exp_nb == 0) begin
      req_valid[u] = 1'b0;
    end else begin
      req_addr[u]    = $urandom;
      req_data[u]    = $urandom;
      req_control[u] = 3'($urandom % 8);
    end
    for (int b = 0; b < exp_nb; b++) begin
      k = 0;
      do begin
        rdy = (stall < 0) ? (($urandom % 2) == 1 || k >= 20) : (k >= stall);
        mem_ready[u] = rdy;
        chk("mem_valid", mem_valid[u], 1);
        chk($sformatf("beat%0d_addr", b), mem_addr[u], exp_addr[b]);
        chk($sformatf("beat%0d_wdata", b), mem_wdata[u], exp_data[b]);
        chk($sformatf("beat%0d_wstrb", b), mem_wstrb[u], exp_strb[b]);
        chk("done_early", done[u], 0);
        chk("req_ready_busy", req_ready[u], 0);
        @(negedge clk);
        k++;
      end while (!rdy);
    end
    req_valid[u] = 1'b0;
    chk("done", done[u], 1);
    chk("err", err[u], exp_err);
    chk("mem_valid_end", mem_valid[u], 0);
    chk("req_ready_end", req_ready[u], 1);
    mem_ready[u] = 1'($urandom % 2);
  endtask

  initial begin
    int          u;
    int          stall;
    logic [31:0] addr;
    logic [2:0]  ctrl;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]   = 1'b0;
      req_addr[i]    = 32'd0;
      req_data[i]    = 32'd0;
      req_control[i] = 3'd0;
      mem_ready[i]   = 1'b0;
    end
    #1;
    chk("rst_mem_valid", mem_valid[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_req_ready", req_ready[0], 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_mem_valid", mem_valid[0], 0);
    chk("post_rst_mem_addr", mem_addr[0], 0);
    chk("post_rst_mem_wdata", mem_wdata[0], 0);
    chk("post_rst_mem_wstrb", mem_wstrb[0], 0);
    chk("post_rst_err", err[0], 0);
    chk("post_rst_req_ready", req_ready[1], 1);

    run_store(0, 32'h0000_0100, 32'hDEAD_BEEF, 3'b011, 0);
    run_store(0, 32'h0000_0103, 32'h1234_56AB, 3'b001, 0);
    run_store(0, 32'h0000_0203, 32'h0000_CAFE, 3'b010, 3);
    run_store(0, 32'hFFFF_FFFE, 32'h1122_3344, 3'b011, 0);
    run_store(1, 32'h0000_0101, 32'h5566_7788, 3'b011, 0);
    run_store(0, 32'h0000_0104, 32'h9999_9999, 3'b111, 0);
    run_store(0, 32'h0000_0108, 32'h0BAD_F00D, 3'b000, 0);
    run_store(1, 32'h0000_0102, 32'hABCD_1234, 3'b010, 2);

    // Reset while the second beat is stalled.
    req_valid[0]   = 1'b1;
    req_addr[0]    = 32'h0000_0302;
    req_data[0]    = 32'hCAFE_F00D;
    req_control[0] = 3'b011;
    @(negedge clk);
    req_valid[0] = 1'b0;
    mem_ready[0] = 1'b1;
    @(negedge clk);
    mem_ready[0] = 1'b0;
    chk("wr1_addr", mem_addr[0], 32'h0000_0304);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_valid", mem_valid[0], 0);
    chk("midrst_mem_addr", mem_addr[0], 0);
    chk("midrst_mem_wstrb", mem_wstrb[0], 0);
    chk("midrst_done", done[0], 0);
    chk("midrst_req_ready", req_ready[0], 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_done", done[0], 0);
    chk("after_rst_mem_valid", mem_valid[0], 0);
    run_store(0, 32'h0000_0040, 32'hA5A5_5A5A, 3'b011, 0);

    for (int it = 0; it < 300; it++) begin
      u    = (($urandom % 4) == 0) ? 1 : 0;
      addr = $urandom;
      if (($urandom % 8) == 0) addr = addr | 32'hFFFF_FFFC;
      ctrl = (($urandom % 8) == 0) ? 3'($urandom % 8) : 3'(1 + ($urandom % 3));
      stall = (($urandom % 2) == 0) ? -1 : int'($urandom % 3);
      run_store(u, addr, $urandom, ctrl, stall);
    end

    @(negedge clk);
    chk("final_done0", done[0], 0);
    chk("final_done1", done[1], 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
